gorev4_histogram_esitleme: RTL
==============================

// Module: gorev4_histogram_esitleme
// PURPOSE
//  Downstream consumer of the 256-bin histogram stream ({bin[7:0], count[23:0]} per word).
//  Builds the cumulative histogram (CDF) and computes an 8-bit equalisation LUT.
//  LUT: lut[k] = floor((cdf[k]-cdf_min)*255 / (N-cdf_min)).
//  Streams the 256 LUT entries to the pixel remap stage.
// PARAMETERS
//  PIKSEL_SAYISI  76800  expected total pixel count (sum of all bins)
//  SAYAC_W        24     width of the count field and of CDF entries
// PORTS
//  clk_i          in   1   single clock, rising edge
//  rst_ni         in   1   asynchronous active-low reset
//  basla_i        in   1   start pulse; accepted only in BOS
//  veri_i         in   32  histogram word {bin[31:24], count[23:0]}
//  veri_gecerli_i in   1   upstream word valid
//  veri_hazir_o   out  1   ready to accept; a transfer occurs when gecerli & hazir are both high
//  veri_o         out  16  LUT word {bin[15:8], lut[7:0]}
//  gecerli_o      out  1   output word valid
//  hazir_i        in   1   downstream ready
//  mesgul_o       out  1   high in every state except BOS and BITTI
//  islem_bitti_o  out  1   high in BITTI until the next basla_i
//  hata_o         out  1   sticky error; cleared by the next accepted basla_i
// BEHAVIOUR
//  Reset:
//   - all outputs 0; FSM in BOS; bin counter, CDF accumulator and cdf_min cleared.
//   - CDF RAM contents are don't-care.
//   - Reset asserted mid-operation aborts immediately; no partial output follows.
//  FSM:
//   - BOS -(basla_i)-> AL.
//   - AL -(256th transfer)-> BOL.
//   - BOL -(bin 255 written)-> GONDER.
//   - GONDER -(256th output handshake)-> BITTI.
//   - BITTI -(basla_i)-> AL.
//   - basla_i is ignored while mesgul_o=1.
//  AL (receive):
//   - veri_hazir_o=1 throughout AL.
//   - Each transfer: acc += count; cdf_ram[k] <= acc+count; k++.
//   - The first nonzero count sets cdf_min = cdf after that bin.
//   - While veri_gecerli_i=0, state holds with no side effects.
//   - On leaving AL: N = final acc.
//   - If N != PIKSEL_SAYISI, set hata_o and continue, using the actual N.
//   - acc is SAYAC_W+1 bits; on overflow into the top bit, set hata_o and saturate.
//  BOL (divide): per bin, in order:
//   - 1 cycle: RAM read.
//   - 1 cycle: form numer = (cdf[k]-cdf_min)*255 (32 bit) and denom = N-cdf_min.
//   - 32 cycles: restoring divide.
//   - 1 cycle: write lut[k].
//   - Total 35 cycles per bin, 8960 cycles for BOL.
//   - cdf[k] < cdf_min (empty leading bins): lut[k]=0, divide skipped, 2 cycles per bin.
//   - denom==0 (all pixels in one bin, or N==0): lut[k]=k (identity); no hata_o.
//   - Quotient is clamped to 255.
//  GONDER (output):
//   - gecerli_o=1 with veri_o={k,lut[k]}; advance on gecerli_o & hazir_i.
//   - veri_o and gecerli_o hold stable while hazir_i=0.
//   - The first word appears 1 cycle after entering GONDER (LUT read latency).
//   - Back-to-back words at 1 per cycle when hazir_i=1.
//   - After the word for bin 255: gecerli_o=0, islem_bitti_o=1.
//  Latency: from the last AL transfer to the first gecerli_o is at most 8962 cycles.
// CONFIGURATION
//  HIST_EQ_BIN_KONTROL_EN defined:
//   - In AL, veri_i[31:24] is compared with the expected bin k.
//   - On mismatch, set hata_o; the word is still accepted as bin k.
//  HIST_EQ_BIN_KONTROL_EN undefined:
//   - veri_i[31:24] is ignored.
//   - hata_o is driven only by the total-count mismatch and overflow conditions.
// TESTING
//  T1 uniform: every bin count=300 -> N=76800, cdf_min=300; lut[k]=k for all k; hata_o=0.
//  T2 single bin: bin 100 = 76800, others 0 -> denom=0, lut[k]=k, hata_o=0.
//  T3 two-level: bins 0 and 255 = 38400 each -> lut[0..254]=0, lut[255]=255.
//  T4 bad total: all bins=1 -> N=256 != 76800, hata_o=1; lut[k]=floor(k*255/255)=k.
//  T5 handshake: random veri_gecerli_i and hazir_i gaps -> identical LUT to T1; veri_o stable while stalled.
//  T6 reset mid-BOL: pull rst_ni low at bin 40 -> all outputs 0 in the same cycle;
//     a fresh T1 run after reset passes; BIN_KONTROL_EN build with bin 7 sent as 0x08 -> hata_o=1.

Source files
------------

// File: rtl/gorev4_histogram_esitleme.sv
// Histogram equalisation: accumulates a 256-bin histogram into a CDF, divides each bin into an 8-bit LUT, streams the LUT out.
// Optional macro HIST_EQ_BIN_KONTROL_EN: flags hata_o when an incoming bin tag differs from the expected bin index.
module gorev4_histogram_esitleme #(
  parameter int PIKSEL_SAYISI = 76800,
  parameter int SAYAC_W       = 24
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        basla_i,
  input  logic [31:0] veri_i,
  input  logic        veri_gecerli_i,
  output logic        veri_hazir_o,
  output logic [15:0] veri_o,
  output logic        gecerli_o,
  input  logic        hazir_i,
  output logic        mesgul_o,
  output logic        islem_bitti_o,
  output logic        hata_o
);

  typedef enum logic [2:0] {BOS, AL, BOL, GONDER, BITTI} durum_t;
  typedef enum logic [1:0] {F_OKU, F_HAZIRLA, F_BOL, F_YAZ} faz_t;

  durum_t durum, durum_next;
  faz_t   faz;

  logic [7:0]         k;
  logic [SAYAC_W:0]   acc;
  logic [SAYAC_W-1:0] cdf_min, n_top, cdf_oku, bolen, kalan;
  logic               min_var, hata;
  logic [31:0]        bolum;
  logic [4:0]         sayac;
  logic [8:0]         rp;
  logic [7:0]         cikis_bin, lut_oku;
  logic               gecerli;

  logic [SAYAC_W-1:0] cdf_ram [256];
  logic [7:0]         lut_ram [256];

  logic               transfer, lut_we, yukle;
  logic [SAYAC_W-1:0] sayim, cdf_yaz, bolen_hesap;
  logic [SAYAC_W:0]   acc_topla, kaydir, fark;
  logic [31:0]        pay;
  logic [7:0]         lut_wd;

  assign transfer    = (durum == AL) && veri_gecerli_i;
  assign sayim       = veri_i[SAYAC_W-1:0];
  assign acc_topla   = acc + {1'b0, sayim};
  // A carry into the top bit saturates the running sum at the largest SAYAC_W value.
  assign cdf_yaz     = acc_topla[SAYAC_W] ? {SAYAC_W{1'b1}} : acc_topla[SAYAC_W-1:0];
  assign bolen_hesap = n_top - cdf_min;
  assign pay         = 32'(cdf_oku - cdf_min) * 32'd255;
  assign kaydir      = {kalan, bolum[31]};
  assign fark        = kaydir - {1'b0, bolen};
  assign yukle       = (durum == GONDER) && (!gecerli || hazir_i) && !rp[8];

`ifndef HIST_EQ_BIN_KONTROL_EN
  logic unused_bin;
  assign unused_bin = ^veri_i[31:24];
`endif

  // Degenerate denominator takes priority so a single-bin image maps to identity.
  always_comb begin
    lut_we = 1'b0;
    lut_wd = 8'd0;
    if (durum == BOL) begin
      if (faz == F_HAZIRLA) begin
        if (bolen_hesap == '0) begin
          lut_we = 1'b1;
          lut_wd = k;
        end else if (cdf_oku < cdf_min) begin
          lut_we = 1'b1;
        end
      end else if (faz == F_YAZ) begin
        lut_we = 1'b1;
        lut_wd = (|bolum[31:8]) ? 8'hFF : bolum[7:0];
      end
    end
  end

  always_comb begin
    durum_next    = durum;
    veri_hazir_o  = 1'b0;
    mesgul_o      = 1'b0;
    islem_bitti_o = 1'b0;
    case (durum)
      BOS:    if (basla_i) durum_next = AL;
      AL: begin
        veri_hazir_o = 1'b1;
        mesgul_o     = 1'b1;
        if (transfer && k == 8'd255) durum_next = BOL;
      end
      BOL: begin
        mesgul_o = 1'b1;
        if (lut_we && k == 8'd255) durum_next = GONDER;
      end
      GONDER: begin
        mesgul_o = 1'b1;
        if (gecerli && hazir_i && cikis_bin == 8'd255) durum_next = BITTI;
      end
      BITTI: begin
        islem_bitti_o = 1'b1;
        if (basla_i) durum_next = AL;
      end
      default: durum_next = BOS;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) durum <= BOS;
    else         durum <= durum_next;
  end

  always_ff @(posedge clk_i) begin
    if (transfer) cdf_ram[k] <= cdf_yaz;
    if (durum == BOL && faz == F_OKU) cdf_oku <= cdf_ram[k];
    if (lut_we) lut_ram[k] <= lut_wd;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      faz <= F_OKU;  k <= '0;  acc <= '0;  cdf_min <= '0;  n_top <= '0;
      min_var <= 1'b0;  hata <= 1'b0;  bolum <= '0;  bolen <= '0;  kalan <= '0;
      sayac <= '0;  rp <= '0;  cikis_bin <= '0;  lut_oku <= '0;  gecerli <= 1'b0;
    end else begin
      case (durum)
        BOS, BITTI: if (basla_i) begin
          k <= '0;  acc <= '0;  cdf_min <= '0;  min_var <= 1'b0;
          hata <= 1'b0;  faz <= F_OKU;  rp <= '0;
        end
        AL: if (transfer) begin
          acc <= {1'b0, cdf_yaz};
          k   <= k + 8'd1;
          if (acc_topla[SAYAC_W]) hata <= 1'b1;
          if (!min_var && sayim != '0) begin
            cdf_min <= cdf_yaz;
            min_var <= 1'b1;
          end
`ifdef HIST_EQ_BIN_KONTROL_EN
          if (veri_i[31:24] != k) hata <= 1'b1;
`endif
          if (k == 8'd255) begin
            n_top <= cdf_yaz;
            if (cdf_yaz != SAYAC_W'(PIKSEL_SAYISI)) hata <= 1'b1;
          end
        end
        BOL: begin
          case (faz)
            F_OKU: faz <= F_HAZIRLA;
            F_HAZIRLA: if (!lut_we) begin
              bolum <= pay;
              bolen <= bolen_hesap;
              kalan <= '0;
              sayac <= '0;
              faz   <= F_BOL;
            end
            F_BOL: begin
              if (!fark[SAYAC_W]) begin
                kalan <= fark[SAYAC_W-1:0];
                bolum <= {bolum[30:0], 1'b1};
              end else begin
                kalan <= kaydir[SAYAC_W-1:0];
                bolum <= {bolum[30:0], 1'b0};
              end
              sayac <= sayac + 5'd1;
              if (sayac == 5'd31) faz <= F_YAZ;
            end
            default: ;
          endcase
          if (lut_we) begin
            k   <= k + 8'd1;
            faz <= F_OKU;
          end
        end
        GONDER: begin
          // The LUT read register doubles as the output register so it holds while stalled.
          if (yukle) begin
            lut_oku   <= lut_ram[rp[7:0]];
            cikis_bin <= rp[7:0];
            rp        <= rp + 9'd1;
            gecerli   <= 1'b1;
          end else if (hazir_i) begin
            gecerli <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign veri_o    = {cikis_bin, lut_oku};
  assign gecerli_o = gecerli;
  assign hata_o    = hata;

endmodule
